// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the fetch stage and the debug unit.
//   NBITS_DEF     default PC/address width
//   PC_RESET_DEF  default PC value loaded on reset
//   CNT_BITS_DEF  default width of the debug cycle counter
//   fetch_state_e fetch FSM encoding, decoded by the debug unit from o_State
//   is_advance()  true when the pipeline advances in the given state
package mips_pkg;

  localparam int          NBITS_DEF    = 32;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam int          CNT_BITS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_e;

  // In single-step mode only the cycle carrying a step pulse advances.
  function automatic logic is_advance(input fetch_state_e state, input logic step);
    return (state == ST_RUN) || ((state == ST_STEP) && step);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// sat_counter: free-running event counter that sticks at all-ones.
//   i_clk    rising-edge clock
//   i_reset  synchronous active-high clear
//   i_inc    count this cycle
//   count    current count value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Once all-ones is reached the value is frozen so the debug unit never
  // sees a small count after a very long run.
  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and fetch control of the pipeline.
//   i_clk       rising-edge clock
//   i_reset     synchronous active-high reset
//   i_PC_next   next PC from the PC-select mux
//   i_Start     begin execution (looked at only while idle)
//   i_ModeStep  0 = continuous run, 1 = single-step (sampled with i_Start)
//   i_Step      single-cycle advance pulse in step mode
//   i_Stall     hold the PC on this advance cycle
//   i_Halt      HALT instruction seen in decode
//   o_PC        registered PC / instruction-memory address
//   o_PC4       o_PC + 4 back to the mux
//   o_PipeEn    pipeline advance enable for this cycle
//   o_Halted    high once halted
//   o_State     FSM state for debug readout
//   o_CycleCnt  saturating count of advance cycles since reset
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int               NBITS    = NBITS_DEF,
  parameter logic [NBITS-1:0] PC_RESET = NBITS'(PC_RESET_DEF),
  parameter int               CNT_BITS = CNT_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NBITS-1:0]    i_PC_next,
  input  logic                i_Start,
  input  logic                i_ModeStep,
  input  logic                i_Step,
  input  logic                i_Stall,
  input  logic                i_Halt,
  output logic [NBITS-1:0]    o_PC,
  output logic [NBITS-1:0]    o_PC4,
  output logic                o_PipeEn,
  output logic                o_Halted,
  output logic [1:0]          o_State,
  output logic [CNT_BITS-1:0] o_CycleCnt
);

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [NBITS-1:0] pc_q;
  logic [NBITS-1:0] pc_d;
  logic             advance;

  assign advance = is_advance(state_q, i_Step);

  // A step pulse arriving together with i_Start is dropped on purpose: the
  // first step only executes once the FSM is already in STEP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d = i_ModeStep ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_Halt) begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (i_Step && i_Halt) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Halt wins over stall; both freeze the PC. Addresses are word aligned,
  // so the low two bits of the mux output are discarded.
  always_comb begin
    pc_d = pc_q;
    if (advance && !i_Halt && !i_Stall) begin
      pc_d = {i_PC_next[NBITS-1:2], 2'b00};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Stalled and halting cycles still count, since the pipeline advances.
  sat_counter #(
    .WIDTH (CNT_BITS)
  ) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (advance),
    .count   (o_CycleCnt)
  );

  assign o_PC     = pc_q;
  assign o_PC4    = pc_q + NBITS'(4);
  assign o_PipeEn = advance;
  assign o_Halted = (state_q == ST_HALTED);
  assign o_State  = state_q;

endmodule
